// File: rtl/rib_pkg.sv
// Shared constants and types for the round-robin RIB interconnect.
package rib_pkg;

    localparam int unsigned SEL_BITS  = 4;

    localparam int unsigned RIB_ROM   = 0;
    localparam int unsigned RIB_RAM   = 1;
    localparam int unsigned RIB_TIMER = 2;
    localparam int unsigned RIB_UART  = 3;
    localparam int unsigned RIB_GPIO  = 4;
    localparam int unsigned RIB_SPI   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rib_state_e;

endpackage

// File: rtl/rib_rr_xbar_if.sv
// Master-side request bus and shared slave bus of the RIB interconnect.
interface rib_rr_xbar_if #(
    parameter int unsigned NM = 4,
    parameter int unsigned NS = 6,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*DW-1:0] m_rdata;
    logic [NM-1:0]    m_gnt;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]    s_we;
    logic             hold_flag;
    logic             err;

    // Interconnect side
    modport slave (
        input  m_req, m_we, m_addr, m_wdata, s_rdata,
        output m_rdata, m_gnt, s_addr, s_wdata, s_we, hold_flag, err
    );

    // Requesters and slaves attached to the interconnect
    modport master (
        output m_req, m_we, m_addr, m_wdata, s_rdata,
        input  m_rdata, m_gnt, s_addr, s_wdata, s_we, hold_flag, err
    );
endinterface

// File: rtl/rib_rr_pick.sv
// One-hot request picker: round-robin starting at ptr, or lowest index first.
module rib_rr_pick #(
    parameter int unsigned NM        = 4,
    parameter int unsigned PRIO_MODE = 0,
    localparam int unsigned PW       = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NM-1:0] gnt_c
);
    int unsigned idx;
    logic        found;

    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NM; i++) begin
            idx = (PRIO_MODE != 0) ? i : ((32'(ptr) + i) % NM);
            if (!found && req[PW'(idx)]) begin
                gnt_c[PW'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rib_rr_xbar.sv
// NM-master to NS-slave RIB interconnect with registered grant, burst
// preemption, address decode, decode-error pulse and core-hold flag.
module rib_rr_xbar
    import rib_pkg::*;
#(
    parameter int unsigned NM        = 4,
    parameter int unsigned NS        = 6,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_BURST = 8,
    parameter logic [NM-1:0] HOLD_MASK = NM'(4'hC)
) (
    input  logic           clk,
    input  logic           rst,
    rib_rr_xbar_if.slave   bus
);
    localparam int unsigned PW      = $clog2(NM);
    localparam int unsigned CNT_MAX = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;
    localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    rib_state_e    state;
    logic [NM-1:0] gnt_q;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          hold_q;
    logic          err_q;

    logic [NM-1:0]       rival_c;
    logic [NM-1:0]       pick_c;
    logic [PW-1:0]       pick_idx_c;
    logic [PW-1:0]       next_ptr_c;
    logic                own_valid_c;
    logic                own_req_c;
    logic                own_we_c;
    logic [AW-1:0]       own_addr_c;
    logic [DW-1:0]       own_wdata_c;
    logic [SEL_BITS-1:0] sel_c;
    logic                sel_ok_c;
    logic [DW-1:0]       slave_rd_c;
    logic                preempt_c;

    assign rival_c     = bus.m_req & ~gnt_q;
    assign own_valid_c = |gnt_q;
    assign own_req_c   = |(bus.m_req & gnt_q);
    assign sel_c       = own_addr_c[AW-1 -: SEL_BITS];
    assign sel_ok_c    = own_valid_c && (32'(sel_c) < NS);
    assign preempt_c   = (MAX_BURST != 0) && (cnt == CW'(CNT_MAX)) && (|rival_c);
    assign next_ptr_c  = (pick_idx_c == PW'(NM - 1)) ? '0 : pick_idx_c + PW'(1);

    // The owner never competes, so it ends up last in round-robin order
    rib_rr_pick #(
        .NM       (NM),
        .PRIO_MODE(PRIO_MODE)
    ) u_pick (
        .req  (rival_c),
        .ptr  (ptr),
        .gnt_c(pick_c)
    );

    always_comb begin
        pick_idx_c = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (pick_c[i]) pick_idx_c = PW'(i);
        end
    end

    // Owner mux; everything is zero while nobody holds the grant
    always_comb begin
        own_we_c    = 1'b0;
        own_addr_c  = '0;
        own_wdata_c = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (gnt_q[i]) begin
                own_we_c    = bus.m_we[i];
                own_addr_c  = bus.m_addr[i*AW +: AW];
                own_wdata_c = bus.m_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        bus.s_we   = '0;
        slave_rd_c = '0;
        for (int unsigned j = 0; j < NS; j++) begin
            if (sel_ok_c && (32'(sel_c) == j)) begin
                bus.s_we[j] = own_we_c && own_req_c;
                slave_rd_c  = bus.s_rdata[j*DW +: DW];
            end
        end
    end

    always_comb begin
        bus.m_rdata = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (gnt_q[i]) bus.m_rdata[i*DW +: DW] = slave_rd_c;
        end
    end

    assign bus.s_addr    = {SEL_BITS'(0), own_addr_c[AW-SEL_BITS-1:0]};
    assign bus.s_wdata   = own_wdata_c;
    assign bus.m_gnt     = gnt_q;
    assign bus.hold_flag = hold_q;
    assign bus.err       = err_q;

    // Arbitration FSM with burst counter, pointer, hold and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            ptr    <= '0;
            cnt    <= '0;
            hold_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hold_q <= |((gnt_q | bus.m_req) & HOLD_MASK);
            err_q  <= own_valid_c && own_req_c && !sel_ok_c;
            case (state)
                IDLE: begin
                    if (|bus.m_req) begin
                        state <= GRANT;
                        gnt_q <= pick_c;
                        ptr   <= next_ptr_c;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if ((!own_req_c || preempt_c) && (|rival_c)) begin
                        gnt_q <= pick_c;
                        ptr   <= next_ptr_c;
                        cnt   <= '0;
                    end else if (!own_req_c) begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end else if (cnt != CW'(CNT_MAX)) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rib_rr_xbar.sv
// Scoreboard bench for rib_rr_xbar: a round-robin instance (MAX_BURST=2) and a
// fixed-priority instance (MAX_BURST=8), each with its own transfer monitor.
module tb_rib_rr_xbar;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [5:0]  we;
        logic [31:0] wd;
        logic [31:0] rd;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_rr;
    logic rst_fx;
    int   checks = 0;
    int   errors = 0;
    xfer_t q_rr[$];
    xfer_t q_fx[$];

    always #5 clk = ~clk;

    rib_rr_xbar_if #(.NM(4), .NS(6), .AW(32), .DW(32)) bus_rr ();
    rib_rr_xbar_if #(.NM(4), .NS(6), .AW(32), .DW(32)) bus_fx ();

    rib_rr_xbar #(.NM(4), .NS(6), .AW(32), .DW(32), .PRIO_MODE(0),
                  .MAX_BURST(2), .HOLD_MASK(4'b1100)) dut_rr (
        .clk(clk), .rst(rst_rr), .bus(bus_rr.slave));

    rib_rr_xbar #(.NM(4), .NS(6), .AW(32), .DW(32), .PRIO_MODE(1),
                  .MAX_BURST(8), .HOLD_MASK(4'b1100)) dut_fx (
        .clk(clk), .rst(rst_fx), .bus(bus_fx.slave));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int which, input int m, input logic [31:0] a,
                        input logic [5:0] w, input logic [31:0] d, input logic [31:0] r);
        xfer_t e;
        e.m = m; e.addr = a; e.we = w; e.wd = d; e.rd = r;
        if (which == 0) q_rr.push_back(e);
        else            q_fx.push_back(e);
    endtask

    task automatic check_xfer(input int which, input string tag, input logic [3:0] gnt,
                              input logic [31:0] addr, input logic [5:0] we,
                              input logic [31:0] wd, input logic [127:0] rd);
        xfer_t e;
        logic [3:0]   eg;
        logic [127:0] er;
        int           n;
        n = (which == 0) ? q_rr.size() : q_fx.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected transfer: gnt=%b addr=%h", tag, gnt, addr);
        end else begin
            if (which == 0) e = q_rr.pop_front();
            else            e = q_fx.pop_front();
            eg = 4'(1 << e.m);
            er = 128'(e.rd) << (e.m * 32);
            chk({tag, " gnt"},    gnt,  eg);
            chk({tag, " s_addr"}, addr, e.addr);
            chk({tag, " s_we"},   we,   e.we);
            chk({tag, " s_wdata"}, wd,  e.wd);
            chk({tag, " m_rdata"}, rd,  er);
        end
    endtask

    // Monitors: any cycle with gnt & req is a transfer and must match the queue head
    always @(negedge clk)
        if (|(bus_rr.m_gnt & bus_rr.m_req))
            check_xfer(0, "rr", bus_rr.m_gnt, bus_rr.s_addr, bus_rr.s_we,
                       bus_rr.s_wdata, bus_rr.m_rdata);

    always @(negedge clk)
        if (|(bus_fx.m_gnt & bus_fx.m_req))
            check_xfer(1, "fx", bus_fx.m_gnt, bus_fx.s_addr, bus_fx.s_we,
                       bus_fx.s_wdata, bus_fx.m_rdata);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int which, input int m, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus_rr.m_req[m] = r;
            bus_rr.m_we[m]  = w;
            bus_rr.m_addr[m*32 +: 32]  = a;
            bus_rr.m_wdata[m*32 +: 32] = d;
        end else begin
            bus_fx.m_req[m] = r;
            bus_fx.m_we[m]  = w;
            bus_fx.m_addr[m*32 +: 32]  = a;
            bus_fx.m_wdata[m*32 +: 32] = d;
        end
    endtask

    task automatic reset_rr();
        bus_rr.m_req = '0; bus_rr.m_we = '0; bus_rr.m_addr = '0; bus_rr.m_wdata = '0;
        rst_rr = 1'b1;
        step();
        step();
        rst_rr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[9];
        order = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        rst_rr = 1'b1;
        rst_fx = 1'b1;
        bus_rr.m_req = '0; bus_rr.m_we = '0; bus_rr.m_addr = '0; bus_rr.m_wdata = '0;
        bus_fx.m_req = '0; bus_fx.m_we = '0; bus_fx.m_addr = '0; bus_fx.m_wdata = '0;
        for (int j = 0; j < 6; j++) begin
            bus_rr.s_rdata[j*32 +: 32] = 32'hA000_0000 + 32'(j);
            bus_fx.s_rdata[j*32 +: 32] = 32'hA000_0000 + 32'(j);
        end
        repeat (3) step();
        rst_rr = 1'b0;
        rst_fx = 1'b0;

        // Reset state with no requests
        @(negedge clk);
        chk("reset gnt",     bus_rr.m_gnt,     4'b0);
        chk("reset s_we",    bus_rr.s_we,      6'b0);
        chk("reset s_addr",  bus_rr.s_addr,    32'h0);
        chk("reset s_wdata", bus_rr.s_wdata,   32'h0);
        chk("reset m_rdata", bus_rr.m_rdata,   128'h0);
        chk("reset hold",    bus_rr.hold_flag, 1'b0);
        chk("reset err",     bus_rr.err,       1'b0);
        chk("reset fx gnt",  bus_fx.m_gnt,     4'b0);

        // m0 writes DEADBEEF to 0x1000_0004 (RAM)
        step();
        set_m(0, 0, 1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        push(0, 0, 32'h0000_0004, 6'b000010, 32'hDEAD_BEEF, 32'hA000_0001);
        @(negedge clk);
        chk("grant latency", bus_rr.m_gnt, 4'b0);
        step();
        step();
        set_m(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Round-robin, all four reading RAM, MAX_BURST=2
        reset_rr();
        for (int i = 0; i < 4; i++)
            set_m(0, i, 1'b1, 1'b0, 32'h1000_0000 + 32'(i * 4), 32'h0000_00F0 + 32'(i));
        for (int k = 0; k < 9; k++)
            push(0, order[k], 32'(order[k] * 4), 6'b0, 32'h0000_00F0 + 32'(order[k]),
                 32'hA000_0001);
        repeat (10) step();
        bus_rr.m_req = '0;
        step();
        step();

        // Fixed priority: m1 and m3 request, m1 owns until it drops req
        set_m(1, 1, 1'b1, 1'b0, 32'h2000_0008, 32'h11);
        set_m(1, 3, 1'b1, 1'b0, 32'h3000_000C, 32'h33);
        repeat (4) push(1, 1, 32'h0000_0008, 6'b0, 32'h11, 32'hA000_0002);
        repeat (3) push(1, 3, 32'h0000_000C, 6'b0, 32'h33, 32'hA000_0003);
        step();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("fx hold c%0d", i), bus_fx.hold_flag, 1'b1);
            step();
            if (i == 4) set_m(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
            if (i == 8) set_m(1, 3, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        step();

        // Decode error: m2 reads 0x7000_0000 with six slaves
        reset_rr();
        set_m(0, 2, 1'b1, 1'b0, 32'h7000_0000, 32'h1234_5678);
        push(0, 2, 32'h0000_0000, 6'b0, 32'h1234_5678, 32'h0);
        step();
        @(negedge clk);
        chk("err before", bus_rr.err, 1'b0);
        step();
        set_m(0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("err pulse", bus_rr.err, 1'b1);
        step();
        @(negedge clk);
        chk("err after", bus_rr.err, 1'b0);
        step();

        // Handover m0 -> m2 with no dead cycle, then m3 wins from ptr=3
        reset_rr();
        set_m(0, 0, 1'b1, 1'b0, 32'h0000_0010, 32'hA0);
        repeat (3) push(0, 0, 32'h0000_0010, 6'b0, 32'hA0, 32'hA000_0000);
        push(0, 2, 32'h0000_0020, 6'b000010, 32'hB2, 32'hA000_0001);
        repeat (2) push(0, 3, 32'h0000_0004, 6'b100000, 32'hC3, 32'hA000_0005);
        repeat (4) step();
        set_m(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(0, 2, 1'b1, 1'b1, 32'h1000_0020, 32'hB2);
        repeat (2) step();
        set_m(0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(0, 1, 1'b1, 1'b0, 32'h2000_0000, 32'hC1);
        set_m(0, 3, 1'b1, 1'b1, 32'h5000_0004, 32'hC3);
        repeat (3) step();
        bus_rr.m_req = '0;
        step();
        step();

        // Synchronous reset in the middle of an m3 write burst
        reset_rr();
        set_m(0, 3, 1'b1, 1'b1, 32'h4000_0020, 32'hCAFE_0003);
        repeat (4) push(0, 3, 32'h0000_0020, 6'b010000, 32'hCAFE_0003, 32'hA000_0004);
        step();
        step();
        @(negedge clk);
        chk("burst hold", bus_rr.hold_flag, 1'b1);
        rst_rr = 1'b1;
        step();
        rst_rr = 1'b0;
        @(negedge clk);
        chk("rst gnt",  bus_rr.m_gnt,     4'b0);
        chk("rst hold", bus_rr.hold_flag, 1'b0);
        chk("rst s_we", bus_rr.s_we,      6'b0);
        repeat (3) step();
        set_m(0, 3, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        chk("rr queue drained", 128'(q_rr.size()), 128'h0);
        chk("fx queue drained", 128'(q_fx.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
